debounce_bank: RTL and testbench



---
 rtl/debounce_pkg.sv | 27 ++
 rtl/debounce_chan.sv | 170 +++++++++++++++++
 rtl/debounce_bank.sv | 44 ++++
 tb/tb_debounce_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types, default constants and sizing helpers for the debounce bank.
// Optional feature macro used by the design: DEBOUNCE_AUTOREPEAT_EN.
package debounce_pkg;

  // Per-channel hold-to-repeat state.
  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Defaults sized for a 100 MHz clock.
  localparam int unsigned DEF_STABLE_CYCLES = 100000;    // 1 ms
  localparam int unsigned DEF_REPEAT_DELAY  = 50000000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD = 10000000;  // 100 ms

  // Bits needed to hold any value in 0..max_count (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Larger of two unsigned values, for sizing shared timers.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One pushbutton channel: synchroniser, stability filter, registered edge
// pulses and, when DEBOUNCE_AUTOREPEAT_EN is defined, a hold-to-repeat FSM.
// Without the macro no repeat logic is built and rpt is constant 0.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic inp,
  output logic outp,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Synchroniser
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  // Shift the raw level into the flop chain; the last stage is the safe copy.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], inp};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser register.
  always_ff @(posedge clk) begin
    // NOTE: the chain is reset too, so a button held through reset has to
    // requalify from scratch instead of being accepted from stale samples.
    if (rst) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples its predecessor's old value.
      sync_q <= sync_d;
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter and edge pulses
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outp_q, outp_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Count consecutive cycles where s disagrees with outp; accept on the last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    outp_d = outp_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != outp_q) begin
      if (cnt_q == CNT_LAST) begin
        outp_d = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Filter and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      outp_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      outp_q <= outp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign outp = outp_q;
  assign rise = rise_q;
  assign fall = fall_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // --------------------------------------------------------------------------
  // Hold-to-repeat FSM
  // --------------------------------------------------------------------------
  localparam int unsigned TMR_W = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

  rpt_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rpt_q, rpt_d;

  // Next state and repeat pulse. The FSM keys off the acceptance event and the
  // next outp value, so the first pulse lands exactly REPEAT_DELAY cycles after
  // rise and a release accepted on a firing cycle suppresses that pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rpt_d   = 1'b0;
    if (!outp_d) begin
      state_d = RPT_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (rise_d) begin
            state_d = RPT_DELAY;
            tmr_d   = '0;
          end
        end
        RPT_DELAY: begin
          if (tmr_q == DLY_LAST) begin
            rpt_d   = 1'b1;
            state_d = RPT_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (tmr_q == PER_LAST) begin
            rpt_d = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = RPT_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Repeat FSM state, timer and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      tmr_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rpt_q   <= rpt_d;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel pushbutton conditioner: NCH independent debounce channels,
// each giving a clean level plus one-cycle rise/fall pulses.
// Optional feature macro: DEBOUNCE_AUTOREPEAT_EN enables hold-to-repeat
// pulses on rpt; without it rpt is constant 0 and REPEAT_* are ignored.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] inp,
  output logic [NCH-1:0] outp,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] rpt
);

  // One fully independent channel per button.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .inp  (inp[i]),
      .outp (outp[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .rpt  (rpt[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (NCH=4, SYNC_STAGES=2,
// STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5). Each scenario pushes
// its expected per-cycle outputs into a queue as it sets up stimulus and pops
// one entry per cycle when the DUT outputs are sampled on the falling edge.
module tb_debounce_bank;

  localparam int LAT = 6;  // SYNC_STAGES + STABLE_CYCLES
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  typedef struct {
    logic [3:0] outp;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] rpt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] inp;
  logic [3:0] outp, rise, fall, rpt;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  debounce_bank #(
    .NCH           (4),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .inp  (inp),
    .outp (outp),
    .rise (rise),
    .fall (fall),
    .rpt  (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rst high for 3 cycles with all buttons held, then release.
  task automatic test_reset();
    exp_t e;
    for (int i = 1; i <= 11; i++) begin
      int j = i - 3;
      e.outp = (j >= LAT) ? 4'hF : 4'h0;
      e.rise = (j == LAT) ? 4'hF : 4'h0;
      e.fall = 4'h0;
      e.rpt  = 4'h0;
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 11; i++) begin
      rst = (i <= 3);
      inp = 4'hF;
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL reset cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
  endtask

  // Drop every button at once; all four fall together.
  task automatic test_release_all();
    exp_t e;
    for (int i = 1; i <= 8; i++) begin
      e.outp = (i < LAT) ? 4'hF : 4'h0;
      e.rise = 4'h0;
      e.fall = (i == LAT) ? 4'hF : 4'h0;
      e.rpt  = 4'h0;
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 8; i++) begin
      inp = 4'h0;
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL release_all cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
  endtask

  // Clean press on ch0 at cycle 0, release at cycle 20. The release is
  // accepted on the cycle a third repeat would fire, so that pulse is absent.
  task automatic test_clean_press();
    exp_t e;
    for (int i = 1; i <= 28; i++) begin
      e.outp = {3'b000, (i >= LAT && i < 20 + LAT)};
      e.rise = {3'b000, (i == LAT)};
      e.fall = {3'b000, (i == 20 + LAT)};
      e.rpt  = {3'b000, RPT_ON && (i == 16 || i == 21)};
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 28; i++) begin
      inp = {3'b000, (i - 1 < 20)};
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL clean_press cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
  endtask

  // ch1 bounces: high 3, low 1, high 2, then low. Nothing is accepted.
  task automatic test_bounce();
    exp_t e;
    for (int i = 1; i <= 14; i++) begin
      e.outp = 4'h0;
      e.rise = 4'h0;
      e.fall = 4'h0;
      e.rpt  = 4'h0;
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 14; i++) begin
      int k = i - 1;
      inp = {2'b00, (k <= 2 || k == 4 || k == 5), 1'b0};
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL bounce cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
  endtask

  // ch3 accepted high first, then ch2 rises while ch3 falls in one cycle.
  task automatic test_simultaneous();
    exp_t e;
    for (int i = 1; i <= 16; i++) begin
      if (i <= 8) begin
        e.outp = (i >= LAT) ? 4'b1000 : 4'b0000;
        e.rise = (i == LAT) ? 4'b1000 : 4'b0000;
        e.fall = 4'b0000;
      end else begin
        e.outp = (i - 8 >= LAT) ? 4'b0100 : 4'b1000;
        e.rise = (i - 8 == LAT) ? 4'b0100 : 4'b0000;
        e.fall = (i - 8 == LAT) ? 4'b1000 : 4'b0000;
      end
      e.rpt = 4'h0;
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 16; i++) begin
      inp = (i <= 8) ? 4'b1000 : 4'b0100;
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL simultaneous cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
  endtask

  // ch0 pressed; one-cycle reset lands when its counter is at 3. No rise
  // appears, everything clears, and the held ch0/ch2 are re-accepted 6 cycles
  // after reset drops.
  task automatic test_reset_mid();
    exp_t e;
    for (int i = 1; i <= 14; i++) begin
      if (i < LAT)       e.outp = 4'b0100;
      else if (i < 12)   e.outp = 4'b0000;
      else               e.outp = 4'b0101;
      e.rise = (i == 12) ? 4'b0101 : 4'b0000;
      e.fall = 4'h0;
      e.rpt  = 4'h0;
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 14; i++) begin
      inp = 4'b0101;
      rst = (i - 1 == 5);
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
    rst = 1'b0;
  endtask

  // Clear everything, then hold ch0: repeats at rise+10, +15, +20 (macro on)
  // and none after the release is accepted.
  task automatic test_repeat();
    exp_t e;
    for (int i = 1; i <= 48; i++) begin
      if (i <= 8) begin
        e.outp = (i < LAT) ? 4'b0101 : 4'b0000;
        e.rise = 4'b0000;
        e.fall = (i == LAT) ? 4'b0101 : 4'b0000;
        e.rpt  = 4'b0000;
      end else begin
        int j = i - 8;
        e.outp = {3'b000, (j >= LAT && j < 22 + LAT)};
        e.rise = {3'b000, (j == LAT)};
        e.fall = {3'b000, (j == 22 + LAT)};
        e.rpt  = {3'b000, RPT_ON && (j == 16 || j == 21 || j == 26)};
      end
      exp_q.push_back(e);
    end
    for (int i = 1; i <= 48; i++) begin
      inp = (i <= 8) ? 4'b0000 : {3'b000, (i - 9 < 22)};
      @(negedge clk);
      e = exp_q.pop_front();
      n_asserts++;
      if ({outp, rise, fall, rpt} !== {e.outp, e.rise, e.fall, e.rpt}) begin
        n_fail++;
        $display("FAIL repeat cycle %0d: outp=%h rise=%h fall=%h rpt=%h, expected outp=%h rise=%h fall=%h rpt=%h",
                 i, outp, rise, fall, rpt, e.outp, e.rise, e.fall, e.rpt);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    inp = 4'h0;
    test_reset();
    test_release_all();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    n_asserts++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
